// File: rtl/apb_modport_if.sv
// Command port of the APB subsystem: host-side transfer request,
// addresses and write data in, last read data out.
interface apb_modport_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;

    modport master (
        output transfer,
        output read_write,
        output apb_write_paddr,
        output apb_write_data,
        output apb_read_paddr,
        input  apb_read_data_out
    );

    modport slave (
        input  transfer,
        input  read_write,
        input  apb_write_paddr,
        input  apb_write_data,
        input  apb_read_paddr,
        output apb_read_data_out
    );
endinterface

// File: rtl/apb_modport.sv
// APB subsystem: master FSM (IDLE/SETUP/ACCESS) driving two zero-wait
// APB memory slaves; address MSB selects the slave.
// Ports: pclk, presetn (sync, active-high), cmd (apb_modport_if.slave).
module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_modport_if.slave cmd
);
    localparam int MW    = AW - 1;
    localparam int DEPTH = 1 << MW;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state_q;
    logic          psel1_q;
    logic          psel2_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] mem1_q [DEPTH];
    logic [DW-1:0] mem2_q [DEPTH];

    logic          pready1;
    logic          pready2;
    logic          pready;
    logic [DW-1:0] prdata;
    logic [AW-1:0] cap_addr;
    logic          capture;

    // Slaves answer in ACCESS with no wait states.
    assign pready1 = psel1_q & penable_q;
    assign pready2 = psel2_q & penable_q;
    assign pready  = pready1 | pready2;
    assign prdata  = paddr_q[AW-1] ? mem2_q[paddr_q[MW-1:0]]
                                   : mem1_q[paddr_q[MW-1:0]];

    // Command inputs are only looked at when a new SETUP is entered.
    assign capture  = cmd.transfer &
                      ((state_q == IDLE) | ((state_q == ACCESS) & pready));
    assign cap_addr = cmd.read_write ? cmd.apb_read_paddr
                                     : cmd.apb_write_paddr;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state_q   <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd.transfer) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        penable_q <= 1'b0;
                        if (cmd.transfer) begin
                            state_q <= SETUP;
                        end else begin
                            state_q <= IDLE;
                            psel1_q <= 1'b0;
                            psel2_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                pwrite_q <= ~cmd.read_write;
                paddr_q  <= cap_addr;
                pwdata_q <= cmd.apb_write_data;
                psel1_q  <= ~cap_addr[AW-1];
                psel2_q  <= cap_addr[AW-1];
            end
        end
    end

    // Reset wins over a write completing on the same edge.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1_q[i] <= '0;
                mem2_q[i] <= '0;
            end
        end else begin
            if (pready1 && pwrite_q) begin
                mem1_q[paddr_q[MW-1:0]] <= pwdata_q;
            end
            if (pready2 && pwrite_q) begin
                mem2_q[paddr_q[MW-1:0]] <= pwdata_q;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (presetn) begin
            rdata_q <= '0;
        end else if (pready && !pwrite_q) begin
            rdata_q <= prdata;
        end
    end

    assign cmd.apb_read_data_out = rdata_q;
endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed scenarios plus random
// command traffic compared against a transaction-level model.
module tb_apb_modport;
    logic pclk;
    logic presetn;

    apb_modport_if #(.AW(9), .DW(8)) bus ();

    apb_modport #(.AW(9), .DW(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .cmd     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a command accepted at edge e completes at e+2;
    // the next command can be accepted at e+2 (back-to-back) or later.
    logic [7:0] mmem [512];
    logic [7:0] exp_rd;
    int         cyc = 0;
    int         free_at = 0;
    int         done_at = 0;
    bit         pend = 1'b0;
    bit         p_rw;
    logic [8:0] p_addr;
    logic [7:0] p_data;

    always @(posedge pclk) begin
        cyc++;
        if (presetn) begin
            for (int i = 0; i < 512; i++) mmem[i] = 8'h00;
            exp_rd  = 8'h00;
            pend    = 1'b0;
            free_at = cyc + 1;
        end else begin
            if (pend && done_at == cyc) begin
                pend = 1'b0;
                if (p_rw) exp_rd = mmem[p_addr];
                else mmem[p_addr] = p_data;
            end
            if (cyc >= free_at && bus.transfer) begin
                pend    = 1'b1;
                done_at = cyc + 2;
                free_at = cyc + 2;
                p_rw    = bus.read_write;
                p_addr  = bus.read_write ? bus.apb_read_paddr
                                         : bus.apb_write_paddr;
                p_data  = bus.apb_write_data;
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_en) check("rd_out_vs_model", bus.apb_read_data_out, exp_rd);
    end

    task automatic idle_inputs();
        bus.transfer        = 1'b0;
        bus.read_write      = 1'bx;
        bus.apb_write_paddr = 'x;
        bus.apb_read_paddr  = 'x;
        bus.apb_write_data  = 'x;
    endtask

    task automatic set_cmd(bit rw, logic [8:0] a, logic [7:0] d);
        bus.transfer   = 1'b1;
        bus.read_write = rw;
        if (rw) begin
            bus.apb_read_paddr  = a;
            bus.apb_write_paddr = 'x;
            bus.apb_write_data  = 'x;
        end else begin
            bus.apb_write_paddr = a;
            bus.apb_read_paddr  = 'x;
            bus.apb_write_data  = d;
        end
    endtask

    // Single transaction from IDLE; returns after the completing edge.
    task automatic do_cmd(bit rw, logic [8:0] a, logic [7:0] d);
        set_cmd(rw, a, d);
        @(negedge pclk);
        idle_inputs();
        repeat (2) @(negedge pclk);
    endtask

    task automatic rd_chk(string nm, logic [8:0] a, logic [7:0] exp);
        do_cmd(1'b1, a, 8'h00);
        check(nm, bus.apb_read_data_out, exp);
    endtask

    initial begin
        logic [8:0] ra;
        idle_inputs();
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        presetn = 1'b0;
        chk_en  = 1'b1;
        check("reset_out", bus.apb_read_data_out, 8'h00);
        rd_chk("reset_rd_005", 9'h005, 8'h00);
        rd_chk("reset_rd_105", 9'h105, 8'h00);

        do_cmd(1'b0, 9'h0A5, 8'h3C);
        check("wr_keeps_out", bus.apb_read_data_out, 8'h00);
        // Read latency: still old value one edge before completion.
        set_cmd(1'b1, 9'h0A5, 8'h00);
        @(negedge pclk);
        idle_inputs();
        @(negedge pclk);
        check("rd_latency_early", bus.apb_read_data_out, 8'h00);
        @(negedge pclk);
        check("rd_0A5", bus.apb_read_data_out, 8'h3C);

        do_cmd(1'b0, 9'h012, 8'h11);
        do_cmd(1'b0, 9'h112, 8'h22);
        rd_chk("iso_012", 9'h012, 8'h11);
        rd_chk("iso_112", 9'h112, 8'h22);

        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b0, 9'(i), 8'(8'hA0 + i));
            repeat (2) @(negedge pclk);
        end
        idle_inputs();
        @(negedge pclk);
        for (int i = 0; i < 4; i++) begin
            rd_chk("b2b_rd", 9'(i), 8'(8'hA0 + i));
        end

        do_cmd(1'b0, 9'h0FF, 8'hFF);
        do_cmd(1'b0, 9'h1FF, 8'h7E);
        rd_chk("bnd_0FF", 9'h0FF, 8'hFF);
        rd_chk("bnd_1FF", 9'h1FF, 8'h7E);
        rd_chk("bnd_100", 9'h100, 8'h00);
        rd_chk("bnd_0FF_again", 9'h0FF, 8'hFF);

        set_cmd(1'b0, 9'h050, 8'h99);
        @(negedge pclk);
        idle_inputs();
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        check("rst_abort_out", bus.apb_read_data_out, 8'h00);
        rd_chk("rst_abort_050", 9'h050, 8'h00);
        rd_chk("rst_clr_0A5", 9'h0A5, 8'h00);

        for (int n = 0; n < 600; n++) begin
            presetn = ($urandom % 80 == 0);
            if ($urandom % 3 != 0) begin
                if ($urandom % 2 == 1) ra = 9'($urandom);
                else ra = {1'($urandom), 8'($urandom % 4)};
                set_cmd(1'($urandom), ra, 8'($urandom));
            end else begin
                idle_inputs();
            end
            @(negedge pclk);
        end
        presetn = 1'b0;
        idle_inputs();
        repeat (4) @(negedge pclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
